// File: rtl/sumador_arbitro.sv
// Round-robin controller that shares one registered adder between two requesters.
// Each request is captured, issued to the adder, timed for SUM_LAT cycles and returned.
module sumador_arbitro #(
  parameter int WIDTH   = 4,
  parameter int SUM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             valid0,
  output logic             valid1,
  output logic [WIDTH-1:0] result,
  output logic             sum_enb,
  output logic [WIDTH-1:0] sum_a,
  output logic [WIDTH-1:0] sum_b,
  input  logic [WIDTH-1:0] sum_c
);

  localparam int            CW       = (SUM_LAT > 1) ? $clog2(SUM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SUM_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic             r_last;
  logic             r_owner;
  logic [CW-1:0]    r_cnt;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_valid0;
  logic             r_valid1;
  logic [WIDTH-1:0] r_result;
  logic             r_sum_enb;
  logic [WIDTH-1:0] r_sum_a;
  logic [WIDTH-1:0] r_sum_b;
  logic             w_any;
  logic             w_pick1;

  // A lone request wins outright; a tie goes to the requester not served last.
  always_comb begin
    w_any = req0 | req1;
    if (req0 && req1) begin
      w_pick1 = ~r_last;
    end else if (req1) begin
      w_pick1 = 1'b1;
    end else begin
      w_pick1 = 1'b0;
    end
  end

  // Controller FSM; sum_a/sum_b double as the captured operand registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_valid0  <= 1'b0;
      r_valid1  <= 1'b0;
      r_result  <= '0;
      r_sum_enb <= 1'b0;
      r_sum_a   <= '0;
      r_sum_b   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner   <= w_pick1;
            r_gnt0    <= ~w_pick1;
            r_gnt1    <= w_pick1;
            r_sum_enb <= 1'b1;
            r_sum_a   <= w_pick1 ? a1 : a0;
            r_sum_b   <= w_pick1 ? b1 : b0;
            r_state   <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_sum_enb <= 1'b0;
          r_cnt     <= CNT_LOAD;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_result <= sum_c;
            r_valid0 <= ~r_owner;
            r_valid1 <= r_owner;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          r_valid0 <= 1'b0;
          r_valid1 <= 1'b0;
          r_last   <= r_owner;
          r_state  <= S_IDLE;
        end
        default: begin
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_valid0  <= 1'b0;
          r_valid1  <= 1'b0;
          r_sum_enb <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign valid0  = r_valid0;
  assign valid1  = r_valid1;
  assign result  = r_result;
  assign sum_enb = r_sum_enb;
  assign sum_a   = r_sum_a;
  assign sum_b   = r_sum_b;

endmodule

// File: tb/tb_sumador_arbitro.sv
// Bench for sumador_arbitro: SUM_LAT=1 and SUM_LAT=3 instances, each with its own adder model
// and a scoreboard of expected (owner, sum) pairs popped on every valid pulse.
module tb_sumador_arbitro;
  localparam int W = 4;

  logic         clk     = 1'b0;
  logic         reset_L = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, valid0, valid1, sum_enb;
  logic [W-1:0] result, sum_a, sum_b;
  logic [W-1:0] sum_c = '0;

  logic         req0_3 = 1'b0, req1_3 = 1'b0;
  logic [W-1:0] a0_3 = '0, b0_3 = '0, a1_3 = '0, b1_3 = '0;
  logic         gnt0_3, gnt1_3, valid0_3, valid1_3, sum_enb_3;
  logic [W-1:0] result_3, sum_a_3, sum_b_3;
  logic [W-1:0] sum_c_3 = '0;

  typedef struct packed {logic who; logic [W-1:0] sum;} exp_t;
  exp_t sb[$];
  exp_t sb3[$];
  logic grant_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_last  = 1'b1;

  sumador_arbitro #(.WIDTH(W), .SUM_LAT(1)) u_dut (
    .clk(clk), .reset_L(reset_L),
    .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1), .result(result),
    .sum_enb(sum_enb), .sum_a(sum_a), .sum_b(sum_b), .sum_c(sum_c)
  );

  sumador_arbitro #(.WIDTH(W), .SUM_LAT(3)) u_dut3 (
    .clk(clk), .reset_L(reset_L),
    .req0(req0_3), .a0(a0_3), .b0(b0_3), .req1(req1_3), .a1(a1_3), .b1(b1_3),
    .gnt0(gnt0_3), .gnt1(gnt1_3), .valid0(valid0_3), .valid1(valid1_3), .result(result_3),
    .sum_enb(sum_enb_3), .sum_a(sum_a_3), .sum_b(sum_b_3), .sum_c(sum_c_3)
  );

  always #5 clk = ~clk;

  // Single-stage adder: c updates only on an enb cycle.
  always @(posedge clk) begin
    if (sum_enb) sum_c <= sum_a + sum_b;
  end

  // Three-stage adder: c valid three edges after the enb cycle.
  logic         d_v [0:1] = '{1'b0, 1'b0};
  logic [W-1:0] d_s [0:1] = '{4'd0, 4'd0};
  always @(posedge clk) begin
    d_v[0] <= sum_enb_3;
    d_s[0] <= sum_a_3 + sum_b_3;
    d_v[1] <= d_v[0];
    d_s[1] <= d_s[0];
    if (d_v[1]) sum_c_3 <= d_s[1];
  end

  // Advance one cycle, score any valid pulse and release requests that were granted.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (valid0 || valid1) begin
      n_tests++;
      if (valid0 && valid1) begin
        n_fail++;
        $display("FAIL valid_overlap: valid0=%0b valid1=%0b, required not both", valid0, valid1);
      end
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: valid1=%0b result=%0d, required no valid", valid1, result);
      end else begin
        e = sb.pop_front();
        m_last = e.who;
        if (valid1 !== e.who || result !== e.sum) begin
          n_fail++;
          $display("FAIL sb_result: owner=%0b result=%0d, required owner=%0b result=%0d",
                   valid1, result, e.who, e.sum);
        end
      end
    end
    if (gnt0 || gnt1) begin
      n_tests++;
      if (gnt0 && gnt1) begin
        n_fail++;
        $display("FAIL gnt_overlap: gnt0=%0b gnt1=%0b, required not both", gnt0, gnt1);
      end
      grant_log.push_back(gnt1);
    end
    if (gnt0) req0 = 1'b0;
    if (gnt1) req1 = 1'b0;
    if (valid0_3 || valid1_3) begin
      n_tests++;
      if (sb3.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid3: result=%0d, required no valid", result_3);
      end else begin
        e = sb3.pop_front();
        if (valid1_3 !== e.who || result_3 !== e.sum) begin
          n_fail++;
          $display("FAIL sb3_result: owner=%0b result=%0d, required owner=%0b result=%0d",
                   valid1_3, result_3, e.who, e.sum);
        end
      end
    end
    if (gnt0_3) req0_3 = 1'b0;
    if (gnt1_3) req1_3 = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!req0 && !req1 && sb.size() == 0) break;
      step();
    end
    n_tests++;
    if (req0 || req1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d req0=%0b req1=%0b, required all served",
               sb.size(), req0, req1);
    end
    step();
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({gnt0, gnt1, valid0, valid1, sum_enb, result, sum_a, sum_b} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: %b, required all zero",
               {gnt0, gnt1, valid0, valid1, sum_enb, result, sum_a, sum_b});
    end
    reset_L = 1'b1;
    m_last = 1'b1;
    step();
    n_tests++;
    if ({gnt0, gnt1, valid0, valid1, sum_enb} !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: %b, required 00000", {gnt0, gnt1, valid0, valid1, sum_enb});
    end
  endtask

  task automatic test_both();
    exp_t e0, e1;
    e0 = '{who: 1'b0, sum: 4'd2};
    e1 = '{who: 1'b1, sum: 4'd7};
    if (m_last) begin sb.push_back(e0); sb.push_back(e1); end
    else begin sb.push_back(e1); sb.push_back(e0); end
    grant_log.delete();
    a0 = 4'd1; b0 = 4'd1; a1 = 4'd3; b1 = 4'd4;
    req0 = 1'b1; req1 = 1'b1;
    wait_drain(40);
    n_tests++;
    if (grant_log.size() != 2 || grant_log[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL both_first_grant: grants=%0d first=%0b, required 2 grants first=0",
               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 1'bx);
    end
  endtask

  task automatic test_single();
    sb.push_back('{who: 1'b0, sum: 4'd7});
    a0 = 4'd5; b0 = 4'd2; req0 = 1'b1;
    step();
    n_tests++;
    if ({gnt0, gnt1, sum_enb, sum_a, sum_b} !== {1'b1, 1'b0, 1'b1, 4'd5, 4'd2}) begin
      n_fail++;
      $display("FAIL single_issue: gnt0=%0b gnt1=%0b enb=%0b a=%0d b=%0d, required 1 0 1 5 2",
               gnt0, gnt1, sum_enb, sum_a, sum_b);
    end
    step();
    n_tests++;
    if ({gnt0, sum_enb, valid0} !== 3'b000 || sum_a !== 4'd5) begin
      n_fail++;
      $display("FAIL single_wait: gnt0=%0b enb=%0b valid0=%0b a=%0d, required 0 0 0 5",
               gnt0, sum_enb, valid0, sum_a);
    end
    step();
    n_tests++;
    if (valid0 !== 1'b1 || result !== 4'd7) begin
      n_fail++;
      $display("FAIL single_done: valid0=%0b result=%0d, required valid0=1 result=7", valid0, result);
    end
    step();
    n_tests++;
    if (valid0 !== 1'b0 || result !== 4'd7) begin
      n_fail++;
      $display("FAIL single_idle: valid0=%0b result=%0d, required valid0=0 result=7", valid0, result);
    end
  endtask

  task automatic test_alternate();
    int   rem0 = 4;
    int   rem1 = 4;
    logic who;
    who = ~m_last;
    for (int k = 0; k < 8; k++) begin
      sb.push_back('{who: who, sum: who ? 4'd13 : 4'd7});
      who = ~who;
    end
    grant_log.delete();
    a0 = 4'd3; b0 = 4'd4; a1 = 4'd8; b1 = 4'd5;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rem0 == 0 && rem1 == 0 && sb.size() == 0) break;
      step();
      if (gnt0) rem0--;
      if (gnt1) rem1--;
      if (rem0 > 0) req0 = 1'b1;
      if (rem1 > 0) req1 = 1'b1;
    end
    n_tests++;
    if (grant_log.size() != 8 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL alt_count: grants=%0d pending=%0d, required 8 and 0", grant_log.size(), sb.size());
    end
    who = ~grant_log[0];
    for (int k = 1; k < grant_log.size(); k++) begin
      n_tests++;
      if (grant_log[k] !== who) begin
        n_fail++;
        $display("FAIL alt_order: grant %0d to %0b, required %0b", k, grant_log[k], who);
      end
      who = ~who;
    end
    step();
  endtask

  task automatic test_overflow();
    sb.push_back('{who: 1'b1, sum: 4'd0});
    a1 = 4'd15; b1 = 4'd1; req1 = 1'b1;
    wait_drain(20);
    sb.push_back('{who: 1'b1, sum: 4'd2});
    a1 = 4'd9; b1 = 4'd9; req1 = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    a0 = 4'd6; b0 = 4'd6; req0 = 1'b1;
    step();
    step();
    n_tests++;
    if (sum_a !== 4'd6 || sum_enb !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait: sum_a=%0d enb=%0b, required 6 0", sum_a, sum_enb);
    end
    reset_L = 1'b0;
    #1;
    n_tests++;
    if ({gnt0, gnt1, valid0, valid1, sum_enb, result, sum_a, sum_b} !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: %b, required all zero",
               {gnt0, gnt1, valid0, valid1, sum_enb, result, sum_a, sum_b});
    end
    step();
    reset_L = 1'b1;
    m_last = 1'b1;
    repeat (4) step();
    sb.push_back('{who: 1'b1, sum: 4'd5});
    a1 = 4'd2; b1 = 4'd3; req1 = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_lat3();
    int k_g = -1;
    int k_v = -1;
    sb3.push_back('{who: 1'b0, sum: 4'd8});
    a0_3 = 4'd4; b0_3 = 4'd4; req0_3 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (gnt0_3 && k_g < 0) k_g = k;
      if (valid0_3) begin k_v = k; break; end
    end
    n_tests++;
    if (k_g != 1 || k_v != 5) begin
      n_fail++;
      $display("FAIL lat3_timing: gnt at %0d valid at %0d, required gnt at 1 valid at 5", k_g, k_v);
    end
    step();
    n_tests++;
    if (valid0_3 !== 1'b0 || sb3.size() != 0) begin
      n_fail++;
      $display("FAIL lat3_done: valid0=%0b pending=%0d, required 0 0", valid0_3, sb3.size());
    end
  endtask

  initial begin
    test_reset();
    test_both();
    test_single();
    test_alternate();
    test_overflow();
    test_reset_mid();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
